// File: rtl/udp_echo_responder.sv
// UDP loopback endpoint: buffers one received datagram and sends the payload back to its sender
// with the source and destination endpoints swapped.
module udp_echo_responder #(
  parameter int unsigned BUFFER_DEPTH = 2048,
  parameter int unsigned IP_TTL       = 64,
  parameter int unsigned COUNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   udp_rx_hdr_valid,
  output logic                   udp_rx_hdr_ready,
  input  logic [31:0]            udp_rx_ip_source_ip,
  input  logic [31:0]            udp_rx_ip_dest_ip,
  input  logic [15:0]            udp_rx_source_port,
  input  logic [15:0]            udp_rx_dest_port,
  input  logic [15:0]            udp_rx_length,
  input  logic [7:0]             udp_rx_payload_tdata,
  input  logic                   udp_rx_payload_tvalid,
  output logic                   udp_rx_payload_tready,
  input  logic                   udp_rx_payload_tlast,
  input  logic                   udp_rx_payload_tuser,
  output logic                   udp_tx_hdr_valid,
  input  logic                   udp_tx_hdr_ready,
  output logic [5:0]             udp_tx_ip_dscp,
  output logic [1:0]             udp_tx_ip_ecn,
  output logic [7:0]             udp_tx_ip_ttl,
  output logic [31:0]            udp_tx_ip_source_ip,
  output logic [31:0]            udp_tx_ip_dest_ip,
  output logic [15:0]            udp_tx_source_port,
  output logic [15:0]            udp_tx_dest_port,
  output logic [15:0]            udp_tx_length,
  output logic [15:0]            udp_tx_checksum,
  output logic [7:0]             udp_tx_payload_tdata,
  output logic                   udp_tx_payload_tvalid,
  input  logic                   udp_tx_payload_tready,
  output logic                   udp_tx_payload_tlast,
  output logic                   udp_tx_payload_tuser,
  input  logic [31:0]            local_ip,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] echo_count,
  output logic [COUNT_WIDTH-1:0] drop_count
);

  localparam int unsigned AW = $clog2(BUFFER_DEPTH);
  localparam logic [AW:0] DepthVal = (AW+1)'(BUFFER_DEPTH);
  localparam logic [AW:0] PtrOne = (AW+1)'(1);
  localparam logic [COUNT_WIDTH-1:0] CountOne = COUNT_WIDTH'(1);

  typedef enum logic [1:0] {StIdle, StRxPayload, StTxHeader, StTxPayload} state_e;

  state_e                 state_q;
  logic                   rx_hdr_ready_q, rx_tready_q, tx_hdr_valid_q, overflow_q;
  logic [31:0]            reply_ip_q;
  logic [15:0]            reply_src_port_q, reply_dst_port_q, tx_length_q;
  logic [AW:0]            wr_ptr_q, rd_ptr_q, byte_count_q;
  logic [COUNT_WIDTH-1:0] echo_q, drop_q;
  logic                   pending_q, pending_last_q;
  logic                   out_valid_q, out_last_q, skid_valid_q, skid_last_q;
  logic [7:0]             out_data_q, skid_data_q, mem_q;
  logic [7:0]             mem [BUFFER_DEPTH];

  logic          rx_beat, mem_we, mem_re, hdr_fire, out_fire;
  logic [1:0]    occ, occ_after;
  logic [AW-1:0] raddr;

  always_comb begin
    rx_beat   = rx_tready_q && udp_rx_payload_tvalid;
    mem_we    = rx_beat && (wr_ptr_q != DepthVal);
    hdr_fire  = tx_hdr_valid_q && udp_tx_hdr_ready;
    out_fire  = out_valid_q && udp_tx_payload_tready;
    occ       = 2'(out_valid_q) + 2'(skid_valid_q) + 2'(pending_q);
    occ_after = occ - 2'(out_fire);
    // Only fetch when the output and skid registers can absorb the byte in flight.
    mem_re    = hdr_fire || ((state_q == StTxPayload) && (rd_ptr_q < byte_count_q) &&
                             (occ_after < 2'd2));
    raddr     = hdr_fire ? '0 : rd_ptr_q[AW-1:0];
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q[AW-1:0]] <= udp_rx_payload_tdata;
    if (mem_re) mem_q <= mem[raddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= StIdle;
      rx_hdr_ready_q   <= 1'b0;
      rx_tready_q      <= 1'b0;
      tx_hdr_valid_q   <= 1'b0;
      overflow_q       <= 1'b0;
      reply_ip_q       <= '0;
      reply_src_port_q <= '0;
      reply_dst_port_q <= '0;
      tx_length_q      <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      byte_count_q     <= '0;
      echo_q           <= '0;
      drop_q           <= '0;
      pending_q        <= 1'b0;
      pending_last_q   <= 1'b0;
      out_valid_q      <= 1'b0;
      out_last_q       <= 1'b0;
      out_data_q       <= '0;
      skid_valid_q     <= 1'b0;
      skid_last_q      <= 1'b0;
      skid_data_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (udp_rx_hdr_valid && rx_hdr_ready_q) begin
            reply_ip_q       <= udp_rx_ip_source_ip;
            reply_dst_port_q <= udp_rx_source_port;
            reply_src_port_q <= udp_rx_dest_port;
            wr_ptr_q         <= '0;
            overflow_q       <= 1'b0;
            rx_hdr_ready_q   <= 1'b0;
            rx_tready_q      <= 1'b1;
            state_q          <= StRxPayload;
          end else begin
            rx_hdr_ready_q <= 1'b1;
          end
        end
        StRxPayload: begin
          if (rx_beat) begin
            if (wr_ptr_q != DepthVal) wr_ptr_q <= wr_ptr_q + PtrOne;
            else                      overflow_q <= 1'b1;
            if (udp_rx_payload_tlast) begin
              rx_tready_q <= 1'b0;
              if (udp_rx_payload_tuser || overflow_q || (wr_ptr_q == DepthVal)) begin
                if (~&drop_q) drop_q <= drop_q + CountOne;
                rx_hdr_ready_q <= 1'b1;
                state_q        <= StIdle;
              end else begin
                byte_count_q   <= wr_ptr_q + PtrOne;
                tx_length_q    <= 16'(wr_ptr_q) + 16'd9;
                tx_hdr_valid_q <= 1'b1;
                state_q        <= StTxHeader;
              end
            end
          end
        end
        StTxHeader: begin
          // The first byte is fetched on the handshake itself to shorten reply latency.
          if (hdr_fire) begin
            tx_hdr_valid_q <= 1'b0;
            rd_ptr_q       <= PtrOne;
            pending_q      <= 1'b1;
            pending_last_q <= (byte_count_q == PtrOne);
            state_q        <= StTxPayload;
          end
        end
        StTxPayload: begin
          if (out_fire && out_last_q) begin
            if (~&echo_q) echo_q <= echo_q + CountOne;
            out_valid_q    <= 1'b0;
            out_last_q     <= 1'b0;
            skid_valid_q   <= 1'b0;
            pending_q      <= 1'b0;
            rx_hdr_ready_q <= 1'b1;
            state_q        <= StIdle;
          end else begin
            pending_q <= mem_re;
            if (mem_re) begin
              rd_ptr_q       <= rd_ptr_q + PtrOne;
              pending_last_q <= (rd_ptr_q == byte_count_q - PtrOne);
            end
            if (out_fire || !out_valid_q) begin
              if (skid_valid_q) begin
                out_valid_q  <= 1'b1;
                out_data_q   <= skid_data_q;
                out_last_q   <= skid_last_q;
                skid_valid_q <= pending_q;
                skid_data_q  <= mem_q;
                skid_last_q  <= pending_last_q;
              end else begin
                out_valid_q <= pending_q;
                out_data_q  <= mem_q;
                out_last_q  <= pending_q && pending_last_q;
              end
            end else if (pending_q) begin
              skid_valid_q <= 1'b1;
              skid_data_q  <= mem_q;
              skid_last_q  <= pending_last_q;
            end
          end
        end
      endcase
    end
  end

  logic unused_rx_fields;
  assign unused_rx_fields = ^{udp_rx_length, udp_rx_ip_dest_ip};

  assign udp_rx_hdr_ready      = rx_hdr_ready_q;
  assign udp_rx_payload_tready = rx_tready_q;
  assign udp_tx_hdr_valid      = tx_hdr_valid_q;
  assign udp_tx_ip_dscp        = 6'd0;
  assign udp_tx_ip_ecn         = 2'd0;
  assign udp_tx_ip_ttl         = 8'(IP_TTL);
  assign udp_tx_ip_source_ip   = local_ip;
  assign udp_tx_ip_dest_ip     = reply_ip_q;
  assign udp_tx_source_port    = reply_src_port_q;
  assign udp_tx_dest_port      = reply_dst_port_q;
  assign udp_tx_length         = tx_length_q;
  assign udp_tx_checksum       = 16'd0;
  assign udp_tx_payload_tdata  = out_data_q;
  assign udp_tx_payload_tvalid = out_valid_q;
  assign udp_tx_payload_tlast  = out_last_q;
  assign udp_tx_payload_tuser  = 1'b0;
  assign busy                  = (state_q != StIdle);
  assign echo_count            = echo_q;
  assign drop_count            = drop_q;

endmodule
